// File: rtl/regfile_scoreboard.sv
// Dual-write, dual-read integer register file with same-cycle write forwarding
// and a per-register load scoreboard that raises a combinational issue stall.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREG),
  localparam int CW       = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read1,
  output logic [XLEN-1:0] read2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write,
  input  logic            reg_write,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_write,
  input  logic            ld_valid,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_is_load,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            set_en, inc, dec;

  function automatic logic is_prot(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A load returning this cycle hides its own hazard only when it is forwarded.
  function automatic logic hazard(input logic [NREG-1:0] bsy, input logic [AW-1:0] r,
                                  input logic ldv, input logic [AW-1:0] ldr);
    return bsy[r] && !is_prot(r) && !((BYPASS != 0) && ldv && (ldr == r));
  endfunction

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] a,
                                               input logic [XLEN-1:0] arr_val);
    logic [XLEN-1:0] v;
    v = arr_val;
    if (is_prot(a))                                        v = '0;
    else if ((BYPASS != 0) && ld_valid  && (ld_rd == a))   v = ld_write;
    else if ((BYPASS != 0) && reg_write && (rd == a))      v = write;
    return v;
  endfunction

  always_comb begin
    read1 = read_mux(rs1, regs_q[rs1]);
    read2 = read_mux(rs2, regs_q[rs2]);
    stall = issue_valid && (hazard(busy_q, rs1, ld_valid, ld_rd) ||
                            hazard(busy_q, rs2, ld_valid, ld_rd) ||
                            hazard(busy_q, issue_rd, ld_valid, ld_rd));
  end

  // NOTE: combinational next-state uses blocking '=' with a full default first,
  // so later statements override earlier ones (port B after port A) and no latch forms.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && !is_prot(rd))   regs_d[rd]    = write;
    if (ld_valid  && !is_prot(ld_rd)) regs_d[ld_rd] = ld_write;
  end

  // Count follows actual bit transitions so it always equals popcount(busy).
  always_comb begin
    set_en = issue_valid && !stall && issue_is_load && !is_prot(issue_rd);
    busy_d = busy_q;
    if (ld_valid) busy_d[ld_rd]    = 1'b0;
    if (set_en)   busy_d[issue_rd] = 1'b1;
    inc   = set_en && !busy_q[issue_rd];
    dec   = ld_valid && busy_q[ld_rd] && !(set_en && (issue_rd == ld_rd));
    cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
  end

  // NOTE: the array is reset too, because every register must read 0 after reset;
  // sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one forwarding instance and one non-forwarding instance share
// all inputs; expected values are hand-computed constants.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, ld_rd, issue_rd;
  logic [31:0] write, ld_write;
  logic        reg_write, ld_valid, issue_valid, issue_is_load;

  logic [31:0] b_read1, b_read2, n_read1, n_read2, b_busy, n_busy;
  logic        b_stall, n_stall;
  logic [5:0]  b_cnt, n_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .read1(b_read1), .read2(b_read2),
    .rd(rd), .write(write), .reg_write(reg_write), .ld_rd(ld_rd), .ld_write(ld_write),
    .ld_valid(ld_valid), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .stall(b_stall), .busy(b_busy), .pending_cnt(b_cnt));

  regfile_scoreboard #(.XLEN(32), .NREG(32), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .read1(n_read1), .read2(n_read2),
    .rd(rd), .write(write), .reg_write(reg_write), .ld_rd(ld_rd), .ld_write(ld_write),
    .ld_valid(ld_valid), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .stall(n_stall), .busy(n_busy), .pending_cnt(n_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rs1 = 0; rs2 = 0; rd = 0; ld_rd = 0; issue_rd = 0;
    write = 0; ld_write = 0;
    reg_write = 0; ld_valid = 0; issue_valid = 0; issue_is_load = 0;
  endtask

  // Advance past the next rising edge and drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic issue_load(input logic [4:0] r);
    issue_valid = 1; issue_is_load = 1; issue_rd = r;
    tick();
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    rs1 = 5; rs2 = 9;
    #3;
    check("rst_read1_b", b_read1, 32'h0);
    check("rst_read2_n", n_read2, 32'h0);
    check("rst_busy_b",  b_busy,  32'h0);
    check("rst_cnt_b",   32'(b_cnt), 32'd0);
    check("rst_stall_b", 32'(b_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Register 0 is protected from writes and forwarding.
    reg_write = 1; rd = 0; write = 32'hDEADBEEF; rs1 = 0;
    #1 check("zero_byp_b", b_read1, 32'h0);
    tick();
    rs1 = 0;
    #1 check("zero_arr_b", b_read1, 32'h0);
    check("zero_arr_n", n_read1, 32'h0);

    // Same-cycle forwarding vs. array path.
    reg_write = 1; rd = 5; write = 32'h12345678; rs1 = 5;
    #1 check("fwd_a_b", b_read1, 32'h12345678);
    check("fwd_a_n", n_read1, 32'h0);
    tick();
    rs1 = 5;
    #1 check("hold_b", b_read1, 32'h12345678);
    check("hold_n", n_read1, 32'h12345678);

    // Dual-write collision: port B wins, in both the forward and array paths.
    reg_write = 1; rd = 7; write = 32'h1; ld_valid = 1; ld_rd = 7; ld_write = 32'h2; rs2 = 7;
    #1 check("coll_fwd_b", b_read2, 32'h2);
    tick();
    rs2 = 7;
    #1 check("coll_arr_b", b_read2, 32'h2);
    check("coll_arr_n", n_read2, 32'h2);
    check("coll_cnt_b", 32'(b_cnt), 32'd0);

    // Load-use stall.
    issue_valid = 1; issue_is_load = 1; issue_rd = 3;
    #1 check("ld3_stall_b", 32'(b_stall), 32'd0);
    tick();
    check("ld3_busy_b", b_busy, 32'h0000_0008);
    check("ld3_busy_n", n_busy, 32'h0000_0008);
    check("ld3_cnt_b",  32'(b_cnt), 32'd1);
    issue_valid = 1; rs2 = 3; issue_rd = 9;
    #1 check("use_stall_b", 32'(b_stall), 32'd1);
    check("use_stall_n", 32'(n_stall), 32'd1);
    ld_valid = 1; ld_rd = 3; ld_write = 32'hAA;
    #1 check("ret_stall_b", 32'(b_stall), 32'd0);
    check("ret_stall_n", 32'(n_stall), 32'd1);
    check("ret_read2_b", b_read2, 32'hAA);
    check("ret_read2_n", n_read2, 32'h0);
    tick();
    check("ret_busy_b", b_busy, 32'h0);
    check("ret_cnt_n",  32'(n_cnt), 32'd0);
    issue_valid = 1; rs2 = 3; issue_rd = 9;
    #1 check("post_stall_n", 32'(n_stall), 32'd0);
    check("post_read2_n", n_read2, 32'hAA);
    tick();

    // Set/clear race on register 4: set wins when forwarding hides the hazard.
    issue_load(5'd4);
    check("r4_busy_b", b_busy, 32'h0000_0010);
    check("r4_cnt_n",  32'(n_cnt), 32'd1);
    ld_valid = 1; ld_rd = 4; ld_write = 32'h44;
    issue_valid = 1; issue_is_load = 1; issue_rd = 4;
    #1 check("race_stall_b", 32'(b_stall), 32'd0);
    check("race_stall_n", 32'(n_stall), 32'd1);
    tick();
    check("race_busy_b", b_busy, 32'h0000_0010);
    check("race_cnt_b",  32'(b_cnt), 32'd1);
    check("race_busy_n", n_busy, 32'h0);
    check("race_cnt_n",  32'(n_cnt), 32'd0);
    ld_valid = 1; ld_rd = 4; ld_write = 32'h45;
    tick();
    check("r4_clr_cnt_b", 32'(b_cnt), 32'd0);

    // A load to the protected register never becomes busy.
    issue_load(5'd0);
    check("ld0_busy_b", b_busy, 32'h0);

    // Async reset with three loads outstanding.
    issue_load(5'd3);
    issue_load(5'd6);
    issue_load(5'd10);
    check("three_busy_b", b_busy, 32'h0000_0448);
    check("three_cnt_n",  32'(n_cnt), 32'd3);
    rs1 = 5; issue_valid = 1; rs2 = 3;
    #1 check("pre_rst_stall_b", 32'(b_stall), 32'd1);
    reset = 1'b0;
    #1 check("mid_rst_busy_b", b_busy, 32'h0);
    check("mid_rst_cnt_b",   32'(b_cnt), 32'd0);
    check("mid_rst_cnt_n",   32'(n_cnt), 32'd0);
    check("mid_rst_stall_b", 32'(b_stall), 32'd0);
    check("mid_rst_read1_b", b_read1, 32'h0);
    issue_valid = 0;
    #1 reset = 1'b1;
    ld_valid = 1; ld_rd = 3; ld_write = 32'h33;
    tick();
    rs1 = 3;
    #1 check("late_ld_read1_b", b_read1, 32'h33);
    check("late_ld_read1_n", n_read1, 32'h33);
    check("late_ld_cnt_b",   32'(b_cnt), 32'd0);
    check("late_ld_busy_n",  n_busy, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised dual-write, dual-read integer register file with a per-register load scoreboard. It sits in the processor decode/writeback stage. Port A takes ALU writeback and port B takes load writeback. A busy bit per register tracks loads that have issued but not returned, and the block raises a combinational stall when an issuing instruction depends on one of them. Same-cycle writes are forwarded to the read ports, so writeback-to-decode needs no extra cycle.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is writable
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports
- AW is localparam $clog2(NREG); CW is localparam $clog2(NREG+1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- rs1, rs2  in  AW  read addresses
- read1, read2  out  XLEN  read data, combinational
- rd  in  AW  port A write address
- write  in  XLEN  port A write data
- reg_write  in  1  port A write enable
- ld_rd  in  AW  port B write address
- ld_write  in  XLEN  port B write data
- ld_valid  in  1  port B write enable; also clears the busy bit
- issue_valid  in  1  an instruction using rs1/rs2/issue_rd is issuing
- issue_rd  in  AW  destination of the issuing instruction
- issue_is_load  in  1  issuing instruction is a load (sets busy)
- stall  out  1  issue must be held, combinational
- busy  out  NREG  scoreboard vector, registered
- pending_cnt  out  CW  number of set busy bits, registered

## Operation
- Protected register: register 0 when ZERO_REG=1. Writes to it are dropped, it never sets busy, and it always reads 0.
- Write priority on a rising edge when both ports target the same register: port B wins.
- Read path, per port: with BYPASS=1, a match on a valid ld_rd returns ld_write. Otherwise a match on a valid rd returns write. Otherwise the array value is returned. With BYPASS=0 the array value is always returned.
- Hazard terms, evaluated combinationally:
  - hz(r) = busy[r] & ~(BYPASS & ld_valid & ld_rd==r)
  - stall = issue_valid & (hz(rs1) | hz(rs2) | hz(issue_rd))
  - The issue_rd term is a WAW check.
  - A protected register 0 never produces a hazard.
- Scoreboard update on a rising edge:
  - The busy bit is set when issue_valid & ~stall & issue_is_load, and issue_rd is not the protected register.
  - The busy bit is cleared when ld_valid targets that register.
  - If set and clear hit the same register in the same cycle, set wins (a new load has been issued).
- pending_cnt equals popcount(busy) at every clock edge. It is maintained incrementally (+1 on set, -1 on clear, 0 when both occur) and never wraps; its maximum is NREG-1 with ZERO_REG=1, otherwise NREG.
- ld_valid to a register whose busy bit is clear is legal: the write happens and the busy bit stays 0.
- reg_write to a busy register is legal: the write happens and the busy bit is unchanged.

## Timing
- Reset asserted, asynchronously:
  - every register reads 0
  - busy = 0, pending_cnt = 0
  - stall = 0
- Release of reset is synchronised by the integrating design.
- Reset asserted mid-operation discards all pending loads; a later ld_valid is treated as a plain write.
- Write latency is one cycle. Data is visible from the array on the cycle after the edge, and in the same cycle through the bypass.
- Busy latency: a load issued in cycle N has busy set from cycle N+1. The matching ld_valid in cycle M clears stall for dependents in cycle M (with BYPASS=1) or in cycle M+1 (with BYPASS=0).
- No read-side latency. read1, read2 and stall are pure combinational functions of the current inputs and state.

## Test plan
- Reset and zero register:
  - hold reset=0 → read1 = read2 = 0, busy = 0, pending_cnt = 0
  - after release, reg_write rd=0 write=0xDEADBEEF → read1 at rs1=0 stays 0
- Basic and bypass:
  - reg_write rd=5 write=0x12345678 with rs1=5 in the same cycle → read1 = 0x12345678 that cycle (BYPASS=1); it holds after the edge
  - with BYPASS=0 → the old value (0) is seen that cycle
- Dual-write collision: rd = ld_rd = 7 in one cycle, write=0x1, ld_write=0x2 → register 7 = 0x2 next cycle.
- Load-use stall:
  - issue load issue_rd=3 → busy[3]=1 and pending_cnt=1 next cycle
  - issue_valid with rs2=3 → stall=1
  - ld_valid ld_rd=3 ld_write=0xAA in that cycle → stall=0 and read2 = 0xAA (BYPASS=1)
- Set/clear race and count: with busy[4]=1, ld_valid ld_rd=4 plus an issuing load issue_rd=4 → busy[4] stays 1 and pending_cnt is unchanged.
- Async reset mid-flight: with 3 loads pending, pulse reset low between edges → busy and pending_cnt go to 0 immediately; a later ld_valid ld_rd=3 writes data and leaves pending_cnt = 0.
